// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared sizes and owner encoding for the memory-port arbiter
package mem_arbiter_pkg;

   localparam int DefaultWordSize = 16;
   localparam int DefaultAddrSize = 14;
   localparam int DefaultMaxBurst = 4;

   // Owner encoding shared with the cpu and DMA blocks
   localparam logic OwnCpu = 1'b0;
   localparam logic OwnDma = 1'b1;

   typedef enum logic {
      OWN0 = OwnCpu,
      OWN1 = OwnDma
   } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin two-requester arbiter for the shared data-memory/IO port
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int WordSize = DefaultWordSize,
   parameter int AddrSize = DefaultAddrSize + 1,
   parameter int MaxBurst = DefaultMaxBurst
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req0,
   input  logic                req1,
   input  logic                we0,
   input  logic                we1,
   input  logic [AddrSize-1:0] addr0,
   input  logic [AddrSize-1:0] addr1,
   input  logic [WordSize-1:0] wdata0,
   input  logic [WordSize-1:0] wdata1,
   output logic                gnt0,
   output logic                gnt1,
   output logic                rvalid0,
   output logic                rvalid1,
   output logic [WordSize-1:0] rdata,
   output logic [AddrSize-1:0] mem_addr,
   output logic [WordSize-1:0] mem_wdata,
   output logic                mem_we,
   output logic                mem_re,
   input  logic [WordSize-1:0] mem_rdata
);

   localparam logic [3:0] MaxBurstC = 4'(MaxBurst);

   // owner_q doubles as "last owner": it survives idle cycles for the tie-break
   owner_e                owner_q, owner_d;
   logic [3:0]            burst_q, burst_d;

   logic                  pick_valid;
   owner_e                pick;
   logic                  keep_owner;

   logic                  sel_we;
   logic [AddrSize-1:0]   sel_addr;
   logic [WordSize-1:0]   sel_wdata;

   logic [AddrSize-1:0]   mem_addr_q;
   logic [WordSize-1:0]   mem_wdata_q;
   logic                  mem_we_q, mem_re_q;

   logic                  tag1_valid_q, tag2_valid_q;
   owner_e                tag1_id_q, tag2_id_q;

   // Pick the winner: a lone requester always wins; on contention the owner keeps
   // the port only while it is mid-burst and under the limit, otherwise it rotates.
   // A zero count means no burst is running, so the non-last owner goes first.
   always_comb begin
      pick_valid = 1'b0;
      pick       = owner_q;
      keep_owner = (burst_q != 4'd0) && (burst_q < MaxBurstC);
      if (req0 && req1) begin
         pick_valid = 1'b1;
         pick       = keep_owner ? owner_q : ((owner_q == OWN0) ? OWN1 : OWN0);
      end else if (req0) begin
         pick_valid = 1'b1;
         pick       = OWN0;
      end else if (req1) begin
         pick_valid = 1'b1;
         pick       = OWN1;
      end
   end

   assign gnt0 = reset && pick_valid && (pick == OWN0);
   assign gnt1 = reset && pick_valid && (pick == OWN1);

   // Mux the winning command toward the command register
   always_comb begin
      sel_we    = (pick == OWN0) ? we0    : we1;
      sel_addr  = (pick == OWN0) ? addr0  : addr1;
      sel_wdata = (pick == OWN0) ? wdata0 : wdata1;
   end

   // Next owner and burst length; the count saturates so lone bursts never wrap
   always_comb begin
      owner_d = owner_q;
      burst_d = 4'd0;
      if (pick_valid) begin
         owner_d = pick;
         if (pick == owner_q) begin
            burst_d = (burst_q == 4'hF) ? 4'hF : burst_q + 4'd1;
         end else begin
            burst_d = 4'd1;
         end
      end
   end

   // Ownership state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner_q <= OWN1;
         burst_q <= 4'd0;
      end else begin
         owner_q <= owner_d;
         burst_q <= burst_d;
      end
   end

   // Command register: strobes pulse for one cycle, address/data hold when idle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         mem_we_q <= pick_valid && sel_we;
         mem_re_q <= pick_valid && !sel_we;
         if (pick_valid) begin
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
         end
      end
   end

   // Read tag pipe: stage 1 lines up with mem_re, stage 2 with mem_rdata
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag1_valid_q <= 1'b0;
         tag1_id_q    <= OWN0;
         tag2_valid_q <= 1'b0;
         tag2_id_q    <= OWN0;
      end else begin
         tag1_valid_q <= pick_valid && !sel_we;
         tag1_id_q    <= pick;
         tag2_valid_q <= tag1_valid_q;
         tag2_id_q    <= tag1_id_q;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_re    = mem_re_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign rvalid0   = tag2_valid_q && (tag2_id_q == OWN0);
   assign rvalid1   = tag2_valid_q && (tag2_id_q == OWN1);
   assign rdata     = mem_rdata;

endmodule
